fetch_unit: RTL and testbench

- Producer side of the decode interface: fetches instruction words from instruction memory and presents them, each with its PC, to control_unit through a valid/ready handshake.
- Holds the architectural fetch PC and a small instruction buffer.
- Handles branch/jump redirects and halt.
- Sits between the imem port of the memory arbiter and the decode stage.

---
 rtl/fetch_pkg.sv | 26 ++
 rtl/fetch_fifo.sv | 60 ++++++
 rtl/fetch_unit.sv | 154 +++++++++++++++
 tb/tb_fetch_unit.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch front end: fetch FSM states and
// the {pc, instr} entry carried through the instruction buffer.
package fetch_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    typedef struct packed {
        word_t pc;
        word_t instr;
    } fetch_entry_t;

    localparam word_t NOP_INSTR = 32'h0000_0013;
    localparam word_t PC_STEP   = 32'd4;

    // Sequential fetch address; 32-bit unsigned so it wraps past 32'hFFFF_FFFC.
    function automatic word_t next_pc(input word_t pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small instruction buffer of fetch entries between imem and decode.
// Flush wins over push and pop; push into a full buffer is accepted only alongside a pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  fetch_entry_t             din,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output fetch_entry_t             head
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t    mem [DEPTH];
    logic [AW-1:0]   rd_ptr_reg;
    logic [AW-1:0]   wr_ptr_reg;
    logic [CW-1:0]   count_reg;
    logic            do_push;
    logic            do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CW'(DEPTH));
    assign count   = count_reg;
    assign head    = mem[rd_ptr_reg];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge CLK) begin
        if (!nRST || flush) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push)
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (do_pop)
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            if (do_push && !do_pop)
                count_reg <= count_reg + CW'(1);
            else if (do_pop && !do_push)
                count_reg <= count_reg - CW'(1);
        end
    end

    // Storage carries no reset; entries are only read while counted valid.
    always_ff @(posedge CLK) begin
        if (do_push && !flush)
            mem[wr_ptr_reg] <= din;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: issues imem requests, buffers returned words with their PC,
// and hands them to decode over valid/ready; handles redirects and halt.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter word_t RESET_PC = 32'h0000_0000,
    parameter int    DEPTH    = 2
) (
    input  logic        CLK,
    input  logic        nRST,
    output logic        imem_ren,
    output logic [31:0] imem_addr,
    input  logic        imem_ihit,
    input  logic [31:0] imem_load,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    input  logic        dec_ready,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        halted
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t  state_reg;
    fetch_state_t  state_next;
    word_t         pc_reg;
    word_t         pc_next;
    word_t         req_addr_reg;
    word_t         req_addr_next;
    logic          active_reg;
    logic          outstanding_reg;
    fetch_entry_t  held_reg;

    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_flush;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    fetch_entry_t  fifo_head;
    fetch_entry_t  fifo_din;
    logic          hit;

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK   (CLK),
        .nRST  (nRST),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (fifo_flush),
        .din   (fifo_din),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count),
        .head  (fifo_head)
    );

    assign fifo_din.pc    = req_addr_reg;
    assign fifo_din.instr = imem_load;
    assign imem_addr      = req_addr_reg;
    assign instr_valid    = !fifo_empty;
    assign hit            = imem_ren && imem_ihit;

    // When the buffer runs dry the last presented entry stays visible.
    assign instr    = fifo_empty ? held_reg.instr : fifo_head.instr;
    assign instr_pc = fifo_empty ? held_reg.pc    : fifo_head.pc;

    // A request once raised is held until its ihit, whatever else happens.
    always_comb begin
        imem_ren = 1'b0;
        halted   = 1'b0;
        unique case (state_reg)
            FETCH:   imem_ren = active_reg && (outstanding_reg || (fifo_count < CW'(DEPTH)));
            DRAIN:   imem_ren = 1'b1;
            HALTED: begin
                imem_ren = outstanding_reg;
                halted   = 1'b1;
            end
            default: imem_ren = 1'b0;
        endcase
    end

    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        req_addr_next = req_addr_reg;
        fifo_push     = 1'b0;
        fifo_pop      = 1'b0;
        fifo_flush    = 1'b0;
        unique case (state_reg)
            FETCH: begin
                if (halt) begin
                    fifo_flush = 1'b1;
                    state_next = HALTED;
                end else if (redirect) begin
                    fifo_flush = 1'b1;
                    pc_next    = redirect_pc;
                    if (imem_ren && !imem_ihit)
                        state_next = DRAIN;
                    else
                        req_addr_next = redirect_pc;
                end else begin
                    fifo_pop = instr_valid && dec_ready;
                    if (hit) begin
                        fifo_push     = !fifo_full || fifo_pop;
                        pc_next       = next_pc(pc_reg);
                        req_addr_next = next_pc(pc_reg);
                    end
                end
            end
            DRAIN: begin
                if (halt) begin
                    fifo_flush = 1'b1;
                    state_next = HALTED;
                end else begin
                    if (redirect) begin
                        fifo_flush = 1'b1;
                        pc_next    = redirect_pc;
                    end
                    if (imem_ihit) begin
                        req_addr_next = redirect ? redirect_pc : pc_reg;
                        state_next    = FETCH;
                    end
                end
            end
            HALTED: state_next = HALTED;
            default: state_next = FETCH;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_reg       <= FETCH;
            pc_reg          <= RESET_PC;
            req_addr_reg    <= RESET_PC;
            active_reg      <= 1'b0;
            outstanding_reg <= 1'b0;
            held_reg        <= '0;
        end else begin
            state_reg       <= state_next;
            pc_reg          <= pc_next;
            req_addr_reg    <= req_addr_next;
            active_reg      <= 1'b1;
            outstanding_reg <= imem_ren && !imem_ihit;
            if (!fifo_empty)
                held_reg <= fifo_head;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus queues expected {pc, word} pairs,
// a monitor pops and compares them at each decode handshake.
`timescale 1ns/1ps
module tb_fetch_unit;

    localparam logic [31:0] KEY = 32'hDEAD_BEEF;

    logic        CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        nRST;
    logic        imem_ren;
    logic [31:0] imem_addr;
    logic        imem_ihit;
    logic [31:0] imem_load;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        dec_ready;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        halted;

    fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .imem_ren    (imem_ren),
        .imem_addr   (imem_addr),
        .imem_ihit   (imem_ihit),
        .imem_load   (imem_load),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt        (halt),
        .dec_ready   (dec_ready),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .halted      (halted)
    );

    // Second instance for address wrap, with a memory that always hits.
    logic        nrst2;
    logic        ren2;
    logic [31:0] addr2;
    logic        ihit2;
    logic [31:0] load2;
    logic        redirect2;
    logic [31:0] redirect_pc2;
    logic        halt2;
    logic        dec_ready2;
    logic        valid2;
    logic [31:0] instr2;
    logic [31:0] instr_pc2;
    logic        halted2;

    assign ihit2      = 1'b1;
    assign load2      = addr2 ^ KEY;
    assign dec_ready2 = 1'b1;

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) dut_wrap (
        .CLK         (CLK),
        .nRST        (nrst2),
        .imem_ren    (ren2),
        .imem_addr   (addr2),
        .imem_ihit   (ihit2),
        .imem_load   (load2),
        .redirect    (redirect2),
        .redirect_pc (redirect_pc2),
        .halt        (halt2),
        .dec_ready   (dec_ready2),
        .instr_valid (valid2),
        .instr       (instr2),
        .instr_pc    (instr_pc2),
        .halted      (halted2)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp2_q[$];
    logic [31:0] slow_addr = 32'hFFFF_FFFF;
    int          slow_delay = 0;
    int          wait_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // Instruction memory model: words are addr^KEY; one address can be made slow.
    always @(negedge CLK) begin
        imem_ihit = 1'b0;
        if (imem_ren) begin
            if (imem_addr == slow_addr && wait_cnt < slow_delay) begin
                wait_cnt++;
            end else begin
                imem_ihit = 1'b1;
                imem_load = imem_addr ^ KEY;
                wait_cnt  = 0;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    always @(negedge CLK) begin : mon_main
        logic [31:0] e;
        if (nRST && instr_valid && dec_ready && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("pop_pc", instr_pc, e);
            check("pop_instr", instr, e ^ KEY);
        end
    end

    always @(negedge CLK) begin : mon_wrap
        logic [31:0] e;
        if (nrst2 && valid2 && exp2_q.size() > 0) begin
            e = exp2_q.pop_front();
            check("wrap_pc", instr_pc2, e);
            check("wrap_instr", instr2, e ^ KEY);
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic reset_dut();
        nRST        = 1'b0;
        redirect    = 1'b0;
        halt        = 1'b0;
        redirect_pc = 32'h0;
        dec_ready   = 1'b1;
        slow_addr   = 32'hFFFF_FFFF;
        slow_delay  = 0;
        exp_q.delete();
        tick();
        tick();
    endtask

    task automatic wait_addr(input string name, input logic [31:0] a);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!(imem_ren && imem_addr == a) && n < 20);
        check(name, imem_addr, a);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() > 0 && n < 100) begin
            tick();
            n++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        nrst2 = 1'b0; redirect2 = 1'b0; halt2 = 1'b0; redirect_pc2 = 32'h0;
        imem_ihit = 1'b0; imem_load = 32'h0;
        reset_dut();

        // Reset values
        check("rst_ren", imem_ren, 0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_valid", instr_valid, 0);
        check("rst_instr", instr, 32'h0);
        check("rst_pc", instr_pc, 32'h0);
        check("rst_halted", halted, 0);

        // Streaming at one instruction per cycle
        for (int i = 0; i < 6; i++) exp_q.push_back(32'(i * 4));
        nRST = 1'b1;
        tick();
        check("t1_ren", imem_ren, 1);
        check("t1_addr0", imem_addr, 32'h0);
        check("t1_valid_lat", instr_valid, 0);
        tick();
        check("t1_valid", instr_valid, 1);
        check("t1_pc0", instr_pc, 32'h0);
        check("t1_addr4", imem_addr, 32'h4);
        tick();
        check("t1_pc4", instr_pc, 32'h4);
        check("t1_addr8", imem_addr, 32'h8);
        wait_drain("t1_drain");

        // Backpressure fills the buffer with exactly two entries
        reset_dut();
        dec_ready = 1'b0;
        nRST = 1'b1;
        repeat (6) tick();
        check("t2_valid", instr_valid, 1);
        check("t2_head", instr_pc, 32'h0);
        check("t2_ren_full", imem_ren, 0);
        check("t2_addr", imem_addr, 32'h8);
        tick();
        check("t2_ren_still", imem_ren, 0);
        for (int i = 0; i < 4; i++) exp_q.push_back(32'(i * 4));
        dec_ready = 1'b1;
        tick();
        check("t2_head4", instr_pc, 32'h4);
        check("t2_resume", imem_ren, 1);
        check("t2_resume_addr", imem_addr, 32'h8);
        wait_drain("t2_drain");

        // Redirect while the request at 0x8 is stalled
        reset_dut();
        slow_addr = 32'h8; slow_delay = 3;
        exp_q.push_back(32'h0); exp_q.push_back(32'h4);
        exp_q.push_back(32'h100); exp_q.push_back(32'h104);
        nRST = 1'b1;
        wait_addr("t3_at8", 32'h8);
        tick();
        redirect = 1'b1; redirect_pc = 32'h100;
        tick();
        redirect = 1'b0;
        check("t3_hold_addr", imem_addr, 32'h8);
        check("t3_hold_ren", imem_ren, 1);
        check("t3_flushed", instr_valid, 0);
        tick();
        check("t3_hold_addr2", imem_addr, 32'h8);
        tick();
        check("t3_new_addr", imem_addr, 32'h100);
        tick();
        check("t3_new_valid", instr_valid, 1);
        check("t3_new_pc", instr_pc, 32'h100);
        wait_drain("t3_drain");

        // Redirect coinciding with ihit and pop
        reset_dut();
        exp_q.push_back(32'h0); exp_q.push_back(32'h4);
        exp_q.push_back(32'h40); exp_q.push_back(32'h44);
        nRST = 1'b1;
        wait_addr("t4_at8", 32'h8);
        check("t4_popping", instr_valid, 1);
        redirect = 1'b1; redirect_pc = 32'h40;
        tick();
        redirect = 1'b0;
        check("t4_empty", instr_valid, 0);
        check("t4_addr", imem_addr, 32'h40);
        tick();
        check("t4_pc40", instr_pc, 32'h40);
        wait_drain("t4_drain");

        // Halt together with redirect while a request is outstanding
        reset_dut();
        slow_addr = 32'h8; slow_delay = 3;
        exp_q.push_back(32'h0); exp_q.push_back(32'h4);
        nRST = 1'b1;
        wait_addr("t5_at8", 32'h8);
        halt = 1'b1; redirect = 1'b1; redirect_pc = 32'h200;
        tick();
        halt = 1'b0; redirect = 1'b0;
        check("t5_halted", halted, 1);
        check("t5_valid", instr_valid, 0);
        check("t5_ren_held", imem_ren, 1);
        check("t5_addr_held", imem_addr, 32'h8);
        begin
            int n = 0;
            while (imem_ren && n < 10) begin
                tick();
                n++;
            end
            check("t5_ren_dropped", imem_ren, 0);
        end
        wait_drain("t5_drain");
        for (int i = 0; i < 3; i++) begin
            redirect = 1'b1; redirect_pc = 32'h300;
            tick();
            redirect = 1'b0;
            tick();
            check("t5_ignore_ren", imem_ren, 0);
            check("t5_ignore_halted", halted, 1);
            check("t5_ignore_valid", instr_valid, 0);
        end
        check("t5_addr_final", imem_addr, 32'h8);

        // Address wrap and mid-stream reset on the second instance
        nRST = 1'b0;
        exp2_q.push_back(32'hFFFF_FFF8); exp2_q.push_back(32'hFFFF_FFFC);
        exp2_q.push_back(32'h0000_0000); exp2_q.push_back(32'h0000_0004);
        nrst2 = 1'b1;
        tick();
        check("t6_addr_f8", addr2, 32'hFFFF_FFF8);
        tick();
        check("t6_addr_fc", addr2, 32'hFFFF_FFFC);
        tick();
        check("t6_addr_0", addr2, 32'h0000_0000);
        begin
            int n = 0;
            while (exp2_q.size() > 0 && n < 50) begin
                tick();
                n++;
            end
            check("t6_drain", 32'(exp2_q.size()), 32'd0);
        end
        check("t6_streaming", valid2, 1);
        nrst2 = 1'b0;
        tick();
        check("t6_rst_ren", ren2, 0);
        check("t6_rst_addr", addr2, 32'hFFFF_FFF8);
        check("t6_rst_valid", valid2, 0);
        check("t6_rst_instr", instr2, 32'h0);
        check("t6_rst_pc", instr_pc2, 32'h0);
        check("t6_rst_halted", halted2, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
